// File: rtl/capture_scope.sv
// Logic-analyser capture engine: arms on a UART command or probe edge, records
// DEPTH samples into block RAM at a 2^R clock interval, then streams them out.
module capture_scope #(
  parameter int NUM_CH  = 8,
  parameter int DEPTH   = 256,
  parameter int TRIG_CH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] probe,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              armed
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [7:0]     HEADER    = 8'hA5;
  localparam logic [AW:0]    LAST_ADDR = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]    READ_END  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DUMP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic              r_trig_prev;
  logic [3:0]        r_rate;
  logic              r_rise_mode;
  logic [9:0]        r_div;
  logic [AW:0]       r_waddr;
  logic [AW:0]       r_raddr;
  logic              r_hdr_sent;
  logic [1:0]        r_gap;
  logic [7:0]        r_tx_data;
  logic              r_new_tx;
  logic [7:0]        r_rdata;
  logic [7:0]        r_mem [DEPTH];

  logic [7:0]        w_sample;
  logic [9:0]        w_div_max;
  logic              w_abort;
  logic              w_is_digit;
  logic              w_trig_cur;
  logic              w_edge;
  logic              w_we;
  logic              w_capture_done;
  logic              w_send;
  logic              w_dump_done;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_sample             = '0;
    w_sample[NUM_CH-1:0] = r_sync2;
  end

  assign w_div_max      = (10'd1 << r_rate) - 10'd1;
  assign w_abort        = new_rx_data && (rx_data == 8'h78);
  assign w_is_digit     = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign w_trig_cur     = r_sync2[TRIG_CH];
  assign w_edge         = r_rise_mode ? (w_trig_cur && !r_trig_prev)
                                      : (!w_trig_cur && r_trig_prev);
  assign w_we           = (r_state == S_CAPTURE) && (r_div == 10'd0);
  assign w_capture_done = w_we && (r_waddr == LAST_ADDR);
  // r_gap keeps tx_busy unsampled for two cycles after a strobe, covering the
  // transmitter's late busy response.
  assign w_send         = (r_state == S_DUMP) && (r_gap == 2'd0) && !tx_busy &&
                          !w_abort && (r_raddr != READ_END);
  assign w_dump_done    = (r_state == S_DUMP) && r_new_tx && (r_raddr == READ_END);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (new_rx_data) begin
          case (rx_data)
            8'h68:        w_next = S_CAPTURE;
            8'h74, 8'h66: w_next = S_ARMED;
            default:      ;
          endcase
        end
      end
      S_ARMED:   if (w_edge)         w_next = S_CAPTURE;
      S_CAPTURE: if (w_capture_done) w_next = S_DUMP;
      S_DUMP:    if (w_dump_done)    w_next = S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_trig_prev <= 1'b0;
    end else begin
      r_sync1     <= probe;
      r_sync2     <= r_sync1;
      r_trig_prev <= r_sync2[TRIG_CH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rate      <= 4'd0;
      r_rise_mode <= 1'b1;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && new_rx_data) begin
        if (w_is_digit)              r_rate      <= rx_data[3:0];
        if (rx_data == 8'h74)        r_rise_mode <= 1'b1;
        else if (rx_data == 8'h66)   r_rise_mode <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_waddr <= '0;
    end else if (r_state != S_CAPTURE) begin
      r_div   <= '0;
      r_waddr <= '0;
    end else begin
      r_div <= (r_div == w_div_max) ? 10'd0 : r_div + 10'd1;
      if (w_we) r_waddr <= (r_waddr == LAST_ADDR) ? '0 : r_waddr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_raddr    <= '0;
      r_hdr_sent <= 1'b0;
      r_gap      <= 2'd0;
      r_tx_data  <= 8'h00;
      r_new_tx   <= 1'b0;
    end else begin
      r_new_tx <= w_send;
      if (r_state != S_DUMP) begin
        r_raddr    <= '0;
        r_hdr_sent <= 1'b0;
        r_gap      <= 2'd0;
      end else begin
        if (r_gap != 2'd0) r_gap <= r_gap - 2'd1;
        if (w_send) begin
          r_gap <= 2'd2;
          if (!r_hdr_sent) begin
            r_hdr_sent <= 1'b1;
            r_tx_data  <= HEADER;
          end else begin
            r_raddr   <= r_raddr + 1'b1;
            r_tx_data <= r_rdata;
          end
        end
      end
    end
  end

  // NOTE: the sample buffer has no reset so it maps onto block RAM; its
  // contents are never read before being written by a capture.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_waddr[AW-1:0]] <= w_sample;
    r_rdata <= r_mem[r_raddr[AW-1:0]];
  end

  assign tx_data     = r_tx_data;
  assign new_tx_data = r_new_tx;
  assign busy        = (r_state != S_IDLE);
  assign armed       = (r_state == S_ARMED);

endmodule
